// File: rtl/btb_predictor_if.sv
// Fetch/EX-side signal bundle for btb_predictor: lookup, resolution, update enable
// and statistics. The CPU side uses the master modport, the predictor the slave modport.
interface btb_predictor_if #(
  parameter int WIDTH = 32
);
  logic             en;
  logic [WIDTH-1:0] IF_PC;
  logic             Pred_Taken;
  logic [WIDTH-1:0] Pred_Target;
  logic             EX_Valid;
  logic [WIDTH-1:0] EX_PC;
  logic             EX_Taken;
  logic [WIDTH-1:0] EX_Target;
  logic             EX_PredTaken;
  logic [WIDTH-1:0] EX_PredTarget;
  logic             Mispredict;
  logic [WIDTH-1:0] Correct_PC;
  logic [15:0]      Branch_Count;
  logic [15:0]      Miss_Count;

  modport master (
    output en, IF_PC, EX_Valid, EX_PC, EX_Taken, EX_Target, EX_PredTaken, EX_PredTarget,
    input  Pred_Taken, Pred_Target, Mispredict, Correct_PC, Branch_Count, Miss_Count
  );

  modport slave (
    input  en, IF_PC, EX_Valid, EX_PC, EX_Taken, EX_Target, EX_PredTaken, EX_PredTarget,
    output Pred_Taken, Pred_Target, Mispredict, Correct_PC, Branch_Count, Miss_Count
  );
endinterface

// File: rtl/btb_predictor.sv
// Direct-mapped branch target buffer with 2-bit saturating direction counters and
// zero-latency lookup. Define BTB_STATS_EN to compile in the branch/miss counters.
module btb_predictor #(
  parameter int WIDTH    = 32,
  parameter int ENTRIES  = 16,
  parameter int TAG_BITS = 8
) (
  input logic            clk,
  input logic            rst,
  btb_predictor_if.slave bus
);
  localparam int IDX = $clog2(ENTRIES);

  logic                valid_q  [ENTRIES];
  logic [TAG_BITS-1:0] tag_q    [ENTRIES];
  logic [WIDTH-1:0]    target_q [ENTRIES];
  logic [1:0]          ctr_q    [ENTRIES];

  function automatic logic [1:0] ctr_inc(input logic [1:0] c);
    return (c == 2'b11) ? c : c + 2'b01;
  endfunction

  function automatic logic [1:0] ctr_dec(input logic [1:0] c);
    return (c == 2'b00) ? c : c - 2'b01;
  endfunction

  logic [IDX-1:0]      if_idx, ex_idx;
  logic [TAG_BITS-1:0] if_tag, ex_tag;
  logic                if_hit, ex_hit, update, mispredict;
  logic                unused_pc_bits;

  assign if_idx = bus.IF_PC[IDX+1:2];
  assign if_tag = bus.IF_PC[IDX+1+TAG_BITS:IDX+2];
  assign ex_idx = bus.EX_PC[IDX+1:2];
  assign ex_tag = bus.EX_PC[IDX+1+TAG_BITS:IDX+2];
  assign unused_pc_bits = ^{bus.IF_PC, bus.EX_PC};

  // Lookup reads pre-update contents; there is deliberately no bypass from EX.
  assign if_hit          = valid_q[if_idx] & (tag_q[if_idx] == if_tag);
  assign bus.Pred_Taken  = if_hit & ctr_q[if_idx][1];
  assign bus.Pred_Target = bus.Pred_Taken ? target_q[if_idx] : bus.IF_PC + WIDTH'(4);

  assign ex_hit     = valid_q[ex_idx] & (tag_q[ex_idx] == ex_tag);
  assign update     = bus.en & bus.EX_Valid;
  assign mispredict = bus.EX_Valid &
                      ((bus.EX_Taken != bus.EX_PredTaken) |
                       (bus.EX_Taken & bus.EX_PredTaken & (bus.EX_Target != bus.EX_PredTarget)));

  assign bus.Mispredict = mispredict;
  assign bus.Correct_PC = bus.EX_Taken ? bus.EX_Target : bus.EX_PC + WIDTH'(4);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i]  <= 1'b0;
        tag_q[i]    <= '0;
        target_q[i] <= '0;
        ctr_q[i]    <= 2'b01;
      end
    end else if (update) begin
      if (ex_hit) begin
        if (bus.EX_Taken) begin
          ctr_q[ex_idx]    <= ctr_inc(ctr_q[ex_idx]);
          target_q[ex_idx] <= bus.EX_Target;
        end else begin
          ctr_q[ex_idx] <= ctr_dec(ctr_q[ex_idx]);
        end
      end else if (bus.EX_Taken) begin
        // A taken miss evicts whatever aliased into this slot, weakly taken.
        valid_q[ex_idx]  <= 1'b1;
        tag_q[ex_idx]    <= ex_tag;
        target_q[ex_idx] <= bus.EX_Target;
        ctr_q[ex_idx]    <= 2'b10;
      end
    end
  end

`ifdef BTB_STATS_EN
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  logic [15:0] branch_cnt_q, miss_cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      branch_cnt_q <= '0;
      miss_cnt_q   <= '0;
    end else if (update) begin
      branch_cnt_q <= sat_inc16(branch_cnt_q);
      if (mispredict) miss_cnt_q <= sat_inc16(miss_cnt_q);
    end
  end

  assign bus.Branch_Count = branch_cnt_q;
  assign bus.Miss_Count   = miss_cnt_q;
`else
  assign bus.Branch_Count = 16'd0;
  assign bus.Miss_Count   = 16'd0;
`endif
endmodule

// File: tb/tb_btb_predictor.sv
// Randomized self-checking bench for btb_predictor against a table-level behavioural model,
// plus directed scenarios with hand-computed expectations.
module tb_btb_predictor;
`ifdef BTB_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  btb_predictor_if #(.WIDTH(32)) bif ();

  btb_predictor #(.WIDTH(32), .ENTRIES(16), .TAG_BITS(8)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bif)
  );

  always #5 clk = ~clk;

  // Behavioural model: 16 slots addressed by arithmetic on the PC.
  bit          m_valid  [16];
  int          m_tag    [16];
  logic [31:0] m_target [16];
  int          m_ctr    [16];
  int          m_bc, m_mc;

  function automatic int idx_of(input logic [31:0] pc);
    return int'((pc / 4) % 16);
  endfunction

  function automatic int tag_of(input logic [31:0] pc);
    return int'((pc / 64) % 256);
  endfunction

  function automatic bit m_hit(input logic [31:0] pc);
    return m_valid[idx_of(pc)] && (m_tag[idx_of(pc)] == tag_of(pc));
  endfunction

  function automatic bit m_pred_taken(input logic [31:0] pc);
    return m_hit(pc) && (m_ctr[idx_of(pc)] >= 2);
  endfunction

  function automatic logic [31:0] m_pred_target(input logic [31:0] pc);
    return m_pred_taken(pc) ? m_target[idx_of(pc)] : pc + 32'd4;
  endfunction

  function automatic bit m_misp();
    if (!bif.EX_Valid) return 1'b0;
    if (bif.EX_Taken != bif.EX_PredTaken) return 1'b1;
    return bif.EX_Taken && (bif.EX_Target != bif.EX_PredTarget);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 16; i++) begin
      m_valid[i] = 1'b0; m_tag[i] = 0; m_target[i] = '0; m_ctr[i] = 1;
    end
    m_bc = 0; m_mc = 0;
  endtask

  task automatic model_update();
    int i;
    bit misp;
    i = idx_of(bif.EX_PC);
    misp = m_misp();
    if (STATS) begin
      if (m_bc < 65535) m_bc++;
      if (misp && m_mc < 65535) m_mc++;
    end
    if (m_hit(bif.EX_PC)) begin
      if (bif.EX_Taken) begin
        m_ctr[i] = (m_ctr[i] == 3) ? 3 : m_ctr[i] + 1;
        m_target[i] = bif.EX_Target;
      end else begin
        m_ctr[i] = (m_ctr[i] == 0) ? 0 : m_ctr[i] - 1;
      end
    end else if (bif.EX_Taken) begin
      m_valid[i] = 1'b1; m_tag[i] = tag_of(bif.EX_PC);
      m_target[i] = bif.EX_Target; m_ctr[i] = 2;
    end
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) model_reset();
    else if (bif.en && bif.EX_Valid) model_update();
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, req, $time);
    end
  endtask

  // Per-cycle comparison against the model, away from the rising edge.
  always @(negedge clk) begin
    if (!rst) begin
      check("pred_taken",   {31'd0, bif.Pred_Taken}, {31'd0, m_pred_taken(bif.IF_PC)});
      check("pred_target",  bif.Pred_Target, m_pred_target(bif.IF_PC));
      check("mispredict",   {31'd0, bif.Mispredict}, {31'd0, m_misp()});
      check("correct_pc",   bif.Correct_PC, bif.EX_Taken ? bif.EX_Target : bif.EX_PC + 32'd4);
      check("branch_count", {16'd0, bif.Branch_Count}, m_bc);
      check("miss_count",   {16'd0, bif.Miss_Count}, m_mc);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present an EX-stage branch whose carried prediction is what the table said.
  task automatic set_ex(input logic [31:0] pc, input logic taken, input logic [31:0] tgt);
    bif.EX_Valid      = 1'b1;
    bif.EX_PC         = pc;
    bif.EX_Taken      = taken;
    bif.EX_Target     = tgt;
    bif.EX_PredTaken  = m_pred_taken(pc);
    bif.EX_PredTarget = m_pred_target(pc);
  endtask

  task automatic upd(input logic [31:0] pc, input logic taken, input logic [31:0] tgt);
    set_ex(pc, taken, tgt);
    tick();
    bif.EX_Valid = 1'b0;
    #1;
  endtask

  task automatic lit(input string name, input logic [31:0] pc, input logic taken,
                     input logic [31:0] tgt);
    bif.IF_PC = pc;
    #1;
    check({name, "_taken"},  {31'd0, bif.Pred_Taken}, {31'd0, taken});
    check({name, "_target"}, bif.Pred_Target, tgt);
  endtask

  function automatic logic [31:0] rand_pc();
    if ($urandom_range(0, 9) == 0) return $urandom() & 32'hFFFF_FFFC;
    return ($urandom_range(0, 3) << 6) | ($urandom_range(0, 15) << 2);
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bif.en = 1'b1; bif.IF_PC = '0; bif.EX_Valid = 1'b0; bif.EX_PC = '0;
    bif.EX_Taken = 1'b0; bif.EX_Target = '0; bif.EX_PredTaken = 1'b0; bif.EX_PredTarget = '0;
    model_reset();
    repeat (2) tick();
    rst = 1'b0;

    // Cold lookup
    lit("cold", 32'h40, 1'b0, 32'h44);
    check("cold_bc", {16'd0, bif.Branch_Count}, 0);
    check("cold_mc", {16'd0, bif.Miss_Count}, 0);

    // Taken allocation
    set_ex(32'h40, 1'b1, 32'h100);
    #1;
    check("alloc_misp", {31'd0, bif.Mispredict}, 1);
    check("alloc_cpc", bif.Correct_PC, 32'h100);
    tick();
    bif.EX_Valid = 1'b0;
    lit("alloc", 32'h40, 1'b1, 32'h100);
    check("alloc_bc", {16'd0, bif.Branch_Count}, STATS ? 1 : 0);
    check("alloc_mc", {16'd0, bif.Miss_Count}, STATS ? 1 : 0);

    // Hysteresis and saturation
    upd(32'h40, 1'b0, 32'h44);
    lit("nt1", 32'h40, 1'b0, 32'h44);
    upd(32'h40, 1'b0, 32'h44);
    upd(32'h40, 1'b0, 32'h44);
    upd(32'h40, 1'b1, 32'h100);
    lit("sat_low", 32'h40, 1'b0, 32'h44);
    upd(32'h40, 1'b1, 32'h100);
    lit("t2", 32'h40, 1'b1, 32'h100);
    upd(32'h40, 1'b1, 32'h100);
    upd(32'h40, 1'b1, 32'h100);
    upd(32'h40, 1'b0, 32'h44);
    lit("sat_high", 32'h40, 1'b1, 32'h100);

    // Alias with same-cycle lookup returning the old entry
    bif.IF_PC = 32'h80;
    set_ex(32'h80, 1'b1, 32'h200);
    lit("same_cycle", 32'h80, 1'b0, 32'h84);
    tick();
    bif.EX_Valid = 1'b0;
    lit("alias_new", 32'h80, 1'b1, 32'h200);
    lit("alias_old", 32'h40, 1'b0, 32'h44);

    // Hold with en=0
    bif.en = 1'b0;
    set_ex(32'h80, 1'b0, 32'h84);
    #1;
    check("hold_misp", {31'd0, bif.Mispredict}, 1);
    tick();
    bif.EX_Valid = 1'b0;
    lit("hold", 32'h80, 1'b1, 32'h200);
    check("hold_bc", {16'd0, bif.Branch_Count}, STATS ? 10 : 0);
    check("hold_mc", {16'd0, bif.Miss_Count}, STATS ? 6 : 0);
    bif.en = 1'b1;

    // Target change on a taken hit
    set_ex(32'h80, 1'b1, 32'h300);
    #1;
    check("jalr_misp", {31'd0, bif.Mispredict}, 1);
    check("jalr_cpc", bif.Correct_PC, 32'h300);
    tick();
    bif.EX_Valid = 1'b0;
    lit("jalr", 32'h80, 1'b1, 32'h300);

    lit("wrap", 32'hFFFF_FFFC, 1'b0, 32'h0);

    // Randomized traffic
    for (int n = 0; n < 1500; n++) begin
      tick();
      bif.en = ($urandom_range(0, 9) != 0);
      bif.IF_PC = ($urandom_range(0, 19) == 0) ? 32'hFFFF_FFFC : rand_pc();
      if ($urandom_range(0, 3) != 0) begin
        set_ex(rand_pc(), 1'($urandom_range(0, 1)),
               ($urandom_range(0, 1) != 0) ? ($urandom() & 32'hFFFF_FFFC) : 32'h100);
        if ($urandom_range(0, 4) == 0) begin
          bif.EX_PredTaken  = 1'($urandom_range(0, 1));
          bif.EX_PredTarget = $urandom();
        end
      end else begin
        bif.EX_Valid = 1'b0;
        bif.EX_PC = $urandom();
        bif.EX_Taken = 1'($urandom_range(0, 1));
        bif.EX_Target = $urandom();
      end
    end

    // Async reset mid-run, then reset across a pending update
    tick();
    bif.en = 1'b1;
    bif.EX_Valid = 1'b0;
    upd(32'h80, 1'b1, 32'h400);
    bif.IF_PC = 32'h80;
    #1;
    rst = 1'b1;
    #1;
    lit("rst_async", 32'h80, 1'b0, 32'h84);
    check("rst_bc", {16'd0, bif.Branch_Count}, 0);
    check("rst_mc", {16'd0, bif.Miss_Count}, 0);
    set_ex(32'h80, 1'b1, 32'h500);
    tick();
    rst = 1'b0;
    bif.EX_Valid = 1'b0;
    lit("rst_discard", 32'h80, 1'b0, 32'h84);
    check("rst_discard_bc", {16'd0, bif.Branch_Count}, 0);
    repeat (3) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
